// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int CNT_W = 4;

  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic                            rd_en,
  input  logic [byte_lanes(DATA_WIDTH)-1:0] be,
  input  logic [IDX_W-1:0]                idx,
  input  logic [DATA_WIDTH-1:0]           wdata,
  output logic [DATA_WIDTH-1:0]           rdata
);

  localparam int LANES = byte_lanes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset wipes every word so no stale data survives an aborted transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < LANES; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      if (rd_en) rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, fixed wait states,
// registered response out with byte-enabled stores and out-of-range errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]             req_wdata,
  input  logic [byte_lanes(DATA_WIDTH)-1:0] req_be,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic                              rsp_err
);

  localparam int LANES = byte_lanes(DATA_WIDTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic accept, execute;

  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [LANES-1:0]      lat_be;

  logic                  acc_write;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [LANES-1:0]      acc_be;
  logic                  in_range;

  logic                  rsp_zero;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // With zero wait states the access runs on the accept edge, so it must use the live request.
  always_comb begin
    acc_write = (state == IDLE) ? req_write : lat_write;
    acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    acc_be    = (state == IDLE) ? req_be    : lat_be;
    in_range  = {1'b0, acc_addr} < DEPTH_LIM;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    execute    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            execute    = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          state_next = RESP;
          execute    = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rsp_err   <= 1'b0;
      rsp_zero  <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (execute) begin
        rsp_err  <= ~in_range;
        rsp_zero <= acc_write | ~in_range;
      end
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .wr_en (execute & acc_write & in_range),
    .rd_en (execute & ~acc_write & in_range),
    .be    (acc_be),
    .idx   (acc_addr[IDX_W-1:0]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_zero ? '0 : arr_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance (9-bit addresses) and a
// zero-wait-state instance, checked every cycle against a transaction-level model.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [8:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(256), .WAIT_CYCLES(2)) dut_w2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(256), .WAIT_CYCLES(0)) dut_w0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wait_cycles(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Transaction-level model: one outstanding access, response due a fixed number of edges after acceptance.
  logic [31:0] mem [2][256];
  bit          m_busy     [2] = '{0, 0};
  int          m_rsp_edge [2] = '{0, 0};
  logic [31:0] m_rdata    [2];
  bit          m_err      [2];
  bit          exp_ready  [2] = '{1, 1};
  bit          exp_valid  [2] = '{0, 0};
  int          edge_cnt = 0;

  always @(posedge clock) begin
    edge_cnt++;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        m_busy[d] = 0;
        for (int i = 0; i < 256; i++) mem[d][i] = '0;
      end else if (exp_valid[d] && rsp_ready[d]) begin
        m_busy[d] = 0;
      end else if (exp_ready[d] && req_valid[d]) begin
        m_busy[d]     = 1;
        m_rsp_edge[d] = edge_cnt + wait_cycles(d);
        if (req_addr[d] >= 9'd256) begin
          m_err[d]   = 1;
          m_rdata[d] = '0;
        end else if (req_write[d]) begin
          m_err[d]   = 0;
          m_rdata[d] = '0;
          for (int b = 0; b < 4; b++)
            if (req_be[d][b]) mem[d][req_addr[d][7:0]][8*b +: 8] = req_wdata[d][8*b +: 8];
        end else begin
          m_err[d]   = 0;
          m_rdata[d] = mem[d][req_addr[d][7:0]];
        end
      end
      exp_ready[d] = !m_busy[d];
      exp_valid[d] = m_busy[d] && (edge_cnt >= m_rsp_edge[d]);
    end
  end

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        check_output($sformatf("d%0d reset req_ready", d), 32'(req_ready[d]), 32'd1);
        check_output($sformatf("d%0d reset rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
        check_output($sformatf("d%0d reset rsp_rdata", d), rsp_rdata[d], 32'd0);
        check_output($sformatf("d%0d reset rsp_err", d), 32'(rsp_err[d]), 32'd0);
      end else begin
        check_output($sformatf("d%0d req_ready", d), 32'(req_ready[d]), 32'(exp_ready[d]));
        check_output($sformatf("d%0d rsp_valid", d), 32'(rsp_valid[d]), 32'(exp_valid[d]));
        if (exp_valid[d]) begin
          check_output($sformatf("d%0d rsp_rdata", d), rsp_rdata[d], m_rdata[d]);
          check_output($sformatf("d%0d rsp_err", d), 32'(rsp_err[d]), 32'(m_err[d]));
        end
      end
    end
  end

  // Issues one request from a negedge; hold>0 keeps rsp_ready low for that many cycles once valid.
  task automatic apply_stimulus(input int d, input bit wr, input logic [8:0] a,
                                input logic [31:0] wd, input logic [3:0] be, input int hold,
                                output logic [31:0] rd, output logic er,
                                output int lat, output int rsp_edge);
    int n;
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_output($sformatf("d%0d ready before request", d), 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    rsp_ready[d] = (hold == 0);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      req_valid[d] = 1'b0;
    end while (!rsp_valid[d] && lat < 40);
    rd       = rsp_rdata[d];
    er       = rsp_err[d];
    rsp_edge = edge_cnt;
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = (i == 1 || i == 3);
      req_write[d] = 1'b0;
      req_addr[d]  = 9'd0;
      @(negedge clock);
      check_output($sformatf("d%0d held rsp_valid", d), 32'(rsp_valid[d]), 32'd1);
      check_output($sformatf("d%0d held rsp_rdata", d), rsp_rdata[d], rd);
      check_output($sformatf("d%0d held req_ready", d), 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clock);
    check_output($sformatf("d%0d ready after handshake", d), 32'(req_ready[d]), 32'd1);
    check_output($sformatf("d%0d valid after handshake", d), 32'(rsp_valid[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          e0, e1, e2;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
      rsp_ready[d] = 1'b0;
    end
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);

    apply_stimulus(0, 1, 9'd5, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, e0);
    check_output("store5 latency", 32'(lat), 32'd3);
    check_output("store5 rdata", rd, 32'd0);
    apply_stimulus(0, 0, 9'd5, 32'h0, 4'h0, 0, rd, er, lat, e0);
    check_output("load5 rdata", rd, 32'hDEADBEEF);
    check_output("load5 err", 32'(er), 32'd0);
    check_output("load5 latency", 32'(lat), 32'd3);

    apply_stimulus(0, 1, 9'd5, 32'h11223344, 4'b0101, 0, rd, er, lat, e0);
    apply_stimulus(0, 0, 9'd5, 32'h0, 4'h0, 0, rd, er, lat, e0);
    check_output("partial store rdata", rd, 32'hDE22BE44);

    apply_stimulus(0, 1, 9'd9, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, e0);
    apply_stimulus(0, 0, 9'd300, 32'h0, 4'h0, 0, rd, er, lat, e0);
    check_output("load300 err", 32'(er), 32'd1);
    check_output("load300 rdata", rd, 32'd0);
    apply_stimulus(0, 0, 9'd0, 32'h0, 4'h0, 0, rd, er, lat, e0);
    check_output("load0 rdata", rd, 32'd0);
    apply_stimulus(0, 0, 9'd9, 32'h0, 4'h0, 0, rd, er, lat, e0);
    check_output("be0 store rdata", rd, 32'd0);

    apply_stimulus(0, 0, 9'd5, 32'h0, 4'h0, 5, rd, er, lat, e0);
    check_output("backpressure rdata", rd, 32'hDE22BE44);

    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 9'd7;
    req_wdata[0] = 32'hCAFEF00D;
    req_be[0]    = 4'hF;
    rsp_ready[0] = 1'b1;
    @(negedge clock);
    req_valid[0] = 1'b0;
    check_output("mid-wait req_ready", 32'(req_ready[0]), 32'd0);
    #1 reset = 1'b0;
    @(negedge clock);
    check_output("abort req_ready", 32'(req_ready[0]), 32'd1);
    check_output("abort rsp_valid", 32'(rsp_valid[0]), 32'd0);
    #1 reset = 1'b1;
    @(negedge clock);
    apply_stimulus(0, 0, 9'd7, 32'h0, 4'h0, 0, rd, er, lat, e0);
    check_output("load7 after abort", rd, 32'd0);
    apply_stimulus(0, 0, 9'd5, 32'h0, 4'h0, 0, rd, er, lat, e0);
    check_output("load5 after reset", rd, 32'd0);

    apply_stimulus(1, 1, 9'd3, 32'hA5A5A5A5, 4'hF, 0, rd, er, lat, e0);
    check_output("w0 store latency", 32'(lat), 32'd1);
    apply_stimulus(1, 0, 9'd3, 32'h0, 4'h0, 0, rd, er, lat, e0);
    check_output("w0 load1 rdata", rd, 32'hA5A5A5A5);
    check_output("w0 load1 latency", 32'(lat), 32'd1);
    apply_stimulus(1, 0, 9'd3, 32'h0, 4'h0, 0, rd, er, lat, e1);
    check_output("w0 load2 latency", 32'(lat), 32'd1);
    apply_stimulus(1, 0, 9'd400, 32'h0, 4'h0, 0, rd, er, lat, e2);
    check_output("w0 load3 err", 32'(er), 32'd1);
    check_output("w0 spacing 1-2", 32'(e1 - e0), 32'd2);
    check_output("w0 spacing 2-3", 32'(e2 - e1), 32'd2);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
